// File: rtl/tlb_op_sequencer_pkg.sv
// Shared TLB op types, FSM state encoding and defaults for the TLB op sequencer.
package core_types;

  localparam int TLBNUM_DEFAULT = 16;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    NOP     = 3'd0,
    TLBRD   = 3'd1,
    TLBWR   = 3'd2,
    TLBFILL = 3'd3,
    TLBSRCH = 3'd4
  } tlb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  function automatic logic is_tlb_op(input logic [2:0] op_type);
    return op_type != NOP;
  endfunction

endpackage

// File: rtl/tlb_op_sequencer_if.sv
// Op / TLB-array / CSR signal bundle of the TLB op sequencer; master is the sequencer side.
interface tlb_op_sequencer_if
  import core_types::*;
#(
  parameter int IDX_W = $clog2(TLBNUM_DEFAULT)
);

  logic             op_valid_i;
  logic [2:0]       op_type_i;
  logic             op_ready_o;
  logic             flush_i;
  logic [IDX_W-1:0] csr_tlbidx_index_i;
  logic             tlb_req_valid_o;
  logic             tlb_req_ready_i;
  logic [2:0]       tlb_req_type_o;
  logic [IDX_W-1:0] tlb_req_index_o;
  logic             tlb_resp_valid_i;
  logic             tlb_resp_hit_i;
  logic [IDX_W-1:0] tlb_resp_index_i;
  logic             csr_srch_we_o;
  logic             csr_srch_hit_o;
  logic [IDX_W-1:0] csr_srch_index_o;
  logic             csr_rd_we_o;
  logic             busy_o;
  logic             refetch_o;

  modport master (
    input  op_valid_i, op_type_i, flush_i, csr_tlbidx_index_i,
           tlb_req_ready_i, tlb_resp_valid_i, tlb_resp_hit_i, tlb_resp_index_i,
    output op_ready_o, tlb_req_valid_o, tlb_req_type_o, tlb_req_index_o,
           csr_srch_we_o, csr_srch_hit_o, csr_srch_index_o, csr_rd_we_o,
           busy_o, refetch_o
  );

  modport slave (
    output op_valid_i, op_type_i, flush_i, csr_tlbidx_index_i,
           tlb_req_ready_i, tlb_resp_valid_i, tlb_resp_hit_i, tlb_resp_index_i,
    input  op_ready_o, tlb_req_valid_o, tlb_req_type_o, tlb_req_index_o,
           csr_srch_we_o, csr_srch_hit_o, csr_srch_index_o, csr_rd_we_o,
           busy_o, refetch_o
  );

endinterface

// File: rtl/tlb_op_sequencer_fill.sv
// TLBFILL victim index generator: round-robin counter by default, or an
// 8-bit free-running LFSR when TLBFILL_LFSR_EN is defined.
module tlb_fill_index_gen
  import core_types::*;
#(
  parameter int TLBNUM = TLBNUM_DEFAULT,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance_i,
  output logic [IDX_W-1:0] index_o
);

`ifdef TLBFILL_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_advance;

  assign unused_advance = advance_i;

  // x^8+x^6+x^5+x^4+1, shifted left; advances every cycle regardless of fills
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign index_o = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // TLBNUM is a power of two, so the natural IDX_W-bit wrap is modulo TLBNUM
  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) cnt_d = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign index_o = cnt_q;
`endif

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences one committed privileged TLB op at a time through the TLB array and
// back to the CSRs. Fill index source selected by TLBFILL_LFSR_EN (see tlb_fill_index_gen).
module tlb_op_sequencer
  import core_types::*;
#(
  parameter int TLBNUM = TLBNUM_DEFAULT,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input logic                clk,
  input logic                rst,
  tlb_op_sequencer_if.master bus
);

  seq_state_t       state_q, state_d;
  tlb_op_t          type_q, type_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

  logic             op_ready;
  logic             req_valid;
  logic             srch_we;
  logic             rd_we;
  logic             refetch;
  logic             fill_adv;
  logic [IDX_W-1:0] fill_idx;

  tlb_fill_index_gen #(
    .TLBNUM (TLBNUM),
    .IDX_W  (IDX_W)
  ) u_fill_index_gen (
    .clk       (clk),
    .rst       (rst),
    .advance_i (fill_adv),
    .index_o   (fill_idx)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    rsp_idx_d = rsp_idx_q;
    op_ready  = 1'b0;
    req_valid = 1'b0;
    srch_we   = 1'b0;
    rd_we     = 1'b0;
    refetch   = 1'b0;
    fill_adv  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid_i && is_tlb_op(bus.op_type_i) && !bus.flush_i) begin
          type_d  = tlb_op_t'(bus.op_type_i);
          idx_d   = (bus.op_type_i == TLBFILL) ? fill_idx : bus.csr_tlbidx_index_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        req_valid = 1'b1;
        // Once the array has taken the request it cannot be recalled, so the
        // handshake outranks a same-cycle flush.
        if (bus.tlb_req_ready_i) begin
          if (bus.tlb_resp_valid_i) begin
            hit_d     = bus.tlb_resp_hit_i;
            rsp_idx_d = bus.tlb_resp_index_i;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (bus.flush_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.tlb_resp_valid_i) begin
          hit_d     = bus.tlb_resp_hit_i;
          rsp_idx_d = bus.tlb_resp_index_i;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        srch_we  = (type_q == TLBSRCH);
        rd_we    = (type_q == TLBRD);
        fill_adv = (type_q == TLBFILL);
        refetch  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Op payload and response capture carry no reset; they are only read behind a strobe
  always_ff @(posedge clk) begin
    type_q    <= type_d;
    idx_q     <= idx_d;
    hit_q     <= hit_d;
    rsp_idx_q <= rsp_idx_d;
  end

  assign bus.op_ready_o       = op_ready;
  assign bus.tlb_req_valid_o  = req_valid;
  assign bus.tlb_req_type_o   = type_q;
  assign bus.tlb_req_index_o  = idx_q;
  assign bus.csr_srch_we_o    = srch_we;
  assign bus.csr_srch_hit_o   = hit_q;
  assign bus.csr_srch_index_o = rsp_idx_q;
  assign bus.csr_rd_we_o      = rd_we;
  assign bus.refetch_o        = refetch;
  assign bus.busy_o           = (state_q != ST_IDLE) ||
                                (bus.op_valid_i && is_tlb_op(bus.op_type_i));

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Self-checking bench for tlb_op_sequencer (TLBNUM=16); works in both TLBFILL_LFSR_EN builds.
module tb_tlb_op_sequencer;
  import core_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
`ifndef TLBFILL_LFSR_EN
  logic [3:0] rr_exp = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  tlb_op_sequencer_if #(.IDX_W(4)) bus ();

  tlb_op_sequencer #(.TLBNUM(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         n_hs;
    logic [2:0] hs_type;
    logic [3:0] hs_idx;
    int         n_srch;
    logic       srch_hit;
    logic [3:0] srch_idx;
    int         n_rd;
    int         n_ref;
    int         ret;
    logic       ready0;
    logic       busy0;
    int         cyc0;
  } obs_t;

`ifdef TLBFILL_LFSR_EN
  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction
`endif

  task automatic drive_idle();
    bus.op_valid_i         = 1'b0;
    bus.op_type_i          = 3'd0;
    bus.flush_i            = 1'b0;
    bus.csr_tlbidx_index_i = 4'd0;
    bus.tlb_req_ready_i    = 1'b0;
    bus.tlb_resp_valid_i   = 1'b0;
    bus.tlb_resp_hit_i     = 1'b0;
    bus.tlb_resp_index_i   = 4'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifndef TLBFILL_LFSR_EN
    rr_exp = '0;
`endif
  endtask

  // Presents one op at k=0, gives the array ready at k=1+rdel, the response
  // rsp_del cycles after that, flush at k=fl_at, and records what the DUT did.
  task automatic run_op(input logic [2:0] t, input logic [3:0] cidx, input int rdel,
                        input int fl_at, input int rsp_del, input logic rhit,
                        input logic [3:0] ridx, input logic [2:0] hold_t, output obs_t o);
    int kh, n;
    kh = 1 + rdel;
    n  = rdel + rsp_del + 6;
    o  = '{default: 0};
    o.ret = -1;
    for (int k = 0; k < n; k++) begin
      bus.op_valid_i         = (k == 0) || (hold_t != 3'd0 && k >= 1 && k <= kh + rsp_del + 1);
      bus.op_type_i          = (k == 0) ? t : hold_t;
      bus.csr_tlbidx_index_i = (k == 0) ? cidx : ~cidx;
      bus.flush_i            = (k == fl_at);
      bus.tlb_req_ready_i    = (k == kh);
      bus.tlb_resp_valid_i   = (k == kh + rsp_del);
      bus.tlb_resp_hit_i     = (k == kh + rsp_del) ? rhit : ~rhit;
      bus.tlb_resp_index_i   = (k == kh + rsp_del) ? ridx : ~ridx;
      @(negedge clk);
      if (k == 0) begin
        o.ready0 = bus.op_ready_o;
        o.busy0  = bus.busy_o;
        o.cyc0   = cyc;
      end
      if (bus.tlb_req_valid_o && bus.tlb_req_ready_i) begin
        o.n_hs++;
        o.hs_type = bus.tlb_req_type_o;
        o.hs_idx  = bus.tlb_req_index_o;
      end
      if (bus.csr_srch_we_o) begin
        o.n_srch++;
        o.srch_hit = bus.csr_srch_hit_o;
        o.srch_idx = bus.csr_srch_index_o;
      end
      if (bus.csr_rd_we_o) o.n_rd++;
      if (bus.refetch_o) o.n_ref++;
      if (k >= 1 && o.ret < 0 && bus.op_ready_o) o.ret = k;
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.op_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready got=%b exp=1", bus.op_ready_o); end
    n_chk++; if (bus.tlb_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", bus.tlb_req_valid_o); end
    n_chk++; if (bus.csr_srch_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_srch_we got=%b exp=0", bus.csr_srch_we_o); end
    n_chk++; if (bus.csr_rd_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_rd_we got=%b exp=0", bus.csr_rd_we_o); end
    n_chk++; if (bus.refetch_o !== 1'b0) begin n_fail++; $display("FAIL rst_refetch got=%b exp=0", bus.refetch_o); end
    n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy_idle got=%b exp=0", bus.busy_o); end
    bus.op_valid_i = 1'b1;
    bus.op_type_i  = TLBRD;
    #1;
    n_chk++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_busy_opvalid got=%b exp=1", bus.busy_o); end
    bus.op_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
`ifndef TLBFILL_LFSR_EN
    rr_exp = '0;
`endif
  endtask

  task automatic test_srch();
    obs_t o;
    run_op(TLBSRCH, 4'd5, 0, -1, 2, 1'b1, 4'd9, 3'd0, o);
    n_chk++; if (o.ready0 !== 1'b1) begin n_fail++; $display("FAIL srch_ready0 got=%b exp=1", o.ready0); end
    n_chk++; if (o.n_hs !== 1) begin n_fail++; $display("FAIL srch_hs_count got=%0d exp=1", o.n_hs); end
    n_chk++; if (o.hs_type !== TLBSRCH) begin n_fail++; $display("FAIL srch_req_type got=%0d exp=4", o.hs_type); end
    n_chk++; if (o.hs_idx !== 4'd5) begin n_fail++; $display("FAIL srch_req_index got=%0d exp=5", o.hs_idx); end
    n_chk++; if (o.n_srch !== 1) begin n_fail++; $display("FAIL srch_we_count got=%0d exp=1", o.n_srch); end
    n_chk++; if (o.srch_hit !== 1'b1) begin n_fail++; $display("FAIL srch_hit got=%b exp=1", o.srch_hit); end
    n_chk++; if (o.srch_idx !== 4'd9) begin n_fail++; $display("FAIL srch_index got=%0d exp=9", o.srch_idx); end
    n_chk++; if (o.n_ref !== 1) begin n_fail++; $display("FAIL srch_refetch got=%0d exp=1", o.n_ref); end
    n_chk++; if (o.n_rd !== 0) begin n_fail++; $display("FAIL srch_rd_we got=%0d exp=0", o.n_rd); end
    n_chk++; if (o.ret !== 5) begin n_fail++; $display("FAIL srch_ready_return got=%0d exp=5", o.ret); end
  endtask

  task automatic test_flush_abort();
    obs_t o;
    run_op(TLBWR, 4'd3, 4, 2, 1, 1'b0, 4'd0, 3'd0, o);
    n_chk++; if (o.n_hs !== 0) begin n_fail++; $display("FAIL abort_hs got=%0d exp=0", o.n_hs); end
    n_chk++; if (o.n_ref !== 0) begin n_fail++; $display("FAIL abort_refetch got=%0d exp=0", o.n_ref); end
    n_chk++; if (o.n_srch + o.n_rd !== 0) begin n_fail++; $display("FAIL abort_csr got=%0d exp=0", o.n_srch + o.n_rd); end
    n_chk++; if (o.ret !== 3) begin n_fail++; $display("FAIL abort_ready_return got=%0d exp=3", o.ret); end
  endtask

  task automatic test_rd_same_cycle();
    obs_t o;
    run_op(TLBRD, 4'd7, 0, -1, 0, 1'b0, 4'd2, 3'd0, o);
    n_chk++; if (o.n_hs !== 1) begin n_fail++; $display("FAIL rd_hs got=%0d exp=1", o.n_hs); end
    n_chk++; if (o.hs_idx !== 4'd7) begin n_fail++; $display("FAIL rd_req_index got=%0d exp=7", o.hs_idx); end
    n_chk++; if (o.n_rd !== 1) begin n_fail++; $display("FAIL rd_we got=%0d exp=1", o.n_rd); end
    n_chk++; if (o.n_srch !== 0) begin n_fail++; $display("FAIL rd_srch_we got=%0d exp=0", o.n_srch); end
    n_chk++; if (o.n_ref !== 1) begin n_fail++; $display("FAIL rd_refetch got=%0d exp=1", o.n_ref); end
    n_chk++; if (o.ret !== 3) begin n_fail++; $display("FAIL rd_accept_to_idle got=%0d exp=3", o.ret); end
  endtask

`ifdef TLBFILL_LFSR_EN
  task automatic test_fill_lfsr();
    obs_t o;
    logic [7:0] v;
    do_reset();
    run_op(TLBFILL, 4'd12, 0, -1, 1, 1'b0, 4'd0, 3'd0, o);
    n_chk++; if (o.hs_idx !== 4'h5) begin n_fail++; $display("FAIL lfsr_first_fill got=%0d exp=5", o.hs_idx); end
    for (int i = 0; i < 6; i++) begin
      run_op(TLBFILL, 4'($urandom), $urandom_range(0, 3), -1, $urandom_range(0, 3), 1'b0, 4'd0, 3'd0, o);
      v = lfsr_after(o.cyc0);
      n_chk++; if (o.hs_idx !== v[3:0]) begin n_fail++; $display("FAIL lfsr_fill_%0d got=%0d exp=%0d", i, o.hs_idx, v[3:0]); end
    end
  endtask
`else
  task automatic test_fill_rr();
    obs_t o;
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_op(TLBFILL, 4'($urandom), $urandom_range(0, 2), -1, $urandom_range(0, 2), 1'b0, 4'd0, 3'd0, o);
      e = 4'(i % 16);
      n_chk++; if (o.hs_idx !== e) begin n_fail++; $display("FAIL rr_fill_%0d got=%0d exp=%0d", i, o.hs_idx, e); end
      n_chk++; if (o.n_srch + o.n_rd !== 0 || o.n_ref !== 1) begin n_fail++; $display("FAIL rr_fill_strobes_%0d got=%0d/%0d exp=0/1", i, o.n_srch + o.n_rd, o.n_ref); end
    end
    rr_exp = 4'd1;
    run_op(TLBFILL, 4'd0, 2, 1, 0, 1'b0, 4'd0, 3'd0, o);
    run_op(TLBFILL, 4'd0, 0, -1, 0, 1'b0, 4'd0, 3'd0, o);
    n_chk++; if (o.hs_idx !== rr_exp) begin n_fail++; $display("FAIL rr_after_abort got=%0d exp=%0d", o.hs_idx, rr_exp); end
    rr_exp = rr_exp + 4'd1;
  endtask
`endif

  task automatic test_back_to_back();
    obs_t o;
    run_op(TLBWR, 4'd6, 1, -1, 1, 1'b1, 4'd3, TLBSRCH, o);
    n_chk++; if (o.n_hs !== 1) begin n_fail++; $display("FAIL b2b_hs got=%0d exp=1", o.n_hs); end
    n_chk++; if (o.hs_type !== TLBWR) begin n_fail++; $display("FAIL b2b_req_type got=%0d exp=2", o.hs_type); end
    n_chk++; if (o.hs_idx !== 4'd6) begin n_fail++; $display("FAIL b2b_req_index got=%0d exp=6", o.hs_idx); end
    n_chk++; if (o.n_srch !== 0) begin n_fail++; $display("FAIL b2b_srch_we got=%0d exp=0", o.n_srch); end
    n_chk++; if (o.n_ref !== 1) begin n_fail++; $display("FAIL b2b_refetch got=%0d exp=1", o.n_ref); end
    run_op(TLBSRCH, 4'd10, 0, -1, 0, 1'b1, 4'd12, 3'd0, o);
    n_chk++; if (o.n_srch !== 1 || o.srch_idx !== 4'd12) begin n_fail++; $display("FAIL b2b_second_srch got=%0d/%0d exp=1/12", o.n_srch, o.srch_idx); end
  endtask

  task automatic test_rst_in_wait();
    int strobes, reqs;
    logic rdy_wait, rdy_after;
    strobes = 0;
    reqs    = 0;
    bus.op_valid_i = 1'b1; bus.op_type_i = TLBRD; bus.csr_tlbidx_index_i = 4'd2;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0; bus.tlb_req_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.tlb_req_ready_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rdy_wait = bus.op_ready_o;
    @(posedge clk); #1;
    rst = 1'b0;
`ifndef TLBFILL_LFSR_EN
    rr_exp = '0;
`endif
    bus.tlb_resp_valid_i = 1'b1; bus.tlb_resp_hit_i = 1'b1; bus.tlb_resp_index_i = 4'd4;
    @(negedge clk);
    rdy_after = bus.op_ready_o;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      strobes += int'(bus.csr_srch_we_o) + int'(bus.csr_rd_we_o) + int'(bus.refetch_o);
      reqs    += int'(bus.tlb_req_valid_o);
      @(posedge clk); #1;
      drive_idle();
    end
    n_chk++; if (rdy_wait !== 1'b0) begin n_fail++; $display("FAIL rstwait_in_wait_ready got=%b exp=0", rdy_wait); end
    n_chk++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL rstwait_idle_ready got=%b exp=1", rdy_after); end
    n_chk++; if (strobes !== 0) begin n_fail++; $display("FAIL rstwait_strobes got=%0d exp=0", strobes); end
    n_chk++; if (reqs !== 0) begin n_fail++; $display("FAIL rstwait_req_valid got=%0d exp=0", reqs); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] t;
    logic [3:0] cidx, ridx, exp_idx;
    logic rhit;
    int rdel, rsp, fl, exp_ret;
    bit acc, abt, comp;
    for (int it = 0; it < 40; it++) begin
      t    = 3'($urandom_range(0, 4));
      cidx = 4'($urandom);
      ridx = 4'($urandom);
      rhit = 1'($urandom);
      rdel = $urandom_range(0, 3);
      rsp  = $urandom_range(0, 3);
      fl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rdel + rsp + 2) : -1;
      run_op(t, cidx, rdel, fl, rsp, rhit, ridx, 3'd0, o);
      acc  = (t != NOP) && (fl != 0);
      abt  = acc && fl >= 1 && fl <= rdel;
      comp = acc && !abt;
      exp_ret = !acc ? 1 : (abt ? fl + 1 : rdel + rsp + 3);
`ifdef TLBFILL_LFSR_EN
      begin
        logic [7:0] v;
        v = lfsr_after(o.cyc0);
        exp_idx = (t == TLBFILL) ? v[3:0] : cidx;
      end
`else
      exp_idx = (t == TLBFILL) ? rr_exp : cidx;
      if (comp && t == TLBFILL) rr_exp = rr_exp + 4'd1;
`endif
      n_chk++; if (o.busy0 !== (t != NOP)) begin n_fail++; $display("FAIL rnd%0d_busy got=%b exp=%b", it, o.busy0, t != NOP); end
      n_chk++; if (o.n_hs !== int'(comp)) begin n_fail++; $display("FAIL rnd%0d_hs got=%0d exp=%0d", it, o.n_hs, comp); end
      if (comp) begin
        n_chk++; if (o.hs_type !== t || o.hs_idx !== exp_idx) begin n_fail++; $display("FAIL rnd%0d_req got=%0d/%0d exp=%0d/%0d", it, o.hs_type, o.hs_idx, t, exp_idx); end
      end
      n_chk++; if (o.n_srch !== int'(comp && t == TLBSRCH)) begin n_fail++; $display("FAIL rnd%0d_srch_we got=%0d", it, o.n_srch); end
      if (comp && t == TLBSRCH) begin
        n_chk++; if (o.srch_hit !== rhit || o.srch_idx !== ridx) begin n_fail++; $display("FAIL rnd%0d_srch_data got=%b/%0d exp=%b/%0d", it, o.srch_hit, o.srch_idx, rhit, ridx); end
      end
      n_chk++; if (o.n_rd !== int'(comp && t == TLBRD)) begin n_fail++; $display("FAIL rnd%0d_rd_we got=%0d", it, o.n_rd); end
      n_chk++; if (o.n_ref !== int'(comp)) begin n_fail++; $display("FAIL rnd%0d_refetch got=%0d exp=%0d", it, o.n_ref, comp); end
      n_chk++; if (o.ret !== exp_ret) begin n_fail++; $display("FAIL rnd%0d_ready_return got=%0d exp=%0d", it, o.ret, exp_ret); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_srch();
    test_flush_abort();
    test_rd_same_cycle();
`ifdef TLBFILL_LFSR_EN
    test_fill_lfsr();
`else
    test_fill_rr();
`endif
    test_back_to_back();
    test_rst_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
